strobe_event_capture: RTL and testbench
=======================================

# strobe_event_capture

Threshold-crossing event recorder that sits directly downstream of the monitor/strobe debug stage and consumes its registered data output. On each qualified rising crossing of a programmable threshold it stores the sample together with a free-running timestamp in a small FIFO. A valid/ready read port drains the FIFO toward the debug readout path.

## Interface

Parameters:
- DATA_WIDTH, 8, width of sampled data
- THRESHOLD, 100, unsigned compare level; an event requires data strictly greater than this value
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
- TS_WIDTH, 16, timestamp counter width

Ports:
- clk_capture  input  1  single clock; all logic on the rising edge
- rst_capture  input  1  asynchronous, active-high reset
- data_in_capture  input  DATA_WIDTH  sample stream, driven by the upstream data_out_monitor
- enable_capture  input  1  arms detection while high
- clear_capture  input  1  synchronous flush; empties the FIFO, clears flags and the timestamp
- rd_ready  input  1  consumer accepts the head entry
- rd_valid  output  1  FIFO is non-empty
- rd_data  output  DATA_WIDTH  head entry: captured sample
- rd_timestamp  output  TS_WIDTH  head entry: capture timestamp
- fifo_count  output  $clog2(DEPTH)+1  number of occupied entries
- overflow  output  1  sticky; set when an event is dropped

## Operation

- **Timestamp counter `ts`:** free-running, increments by 1 every cycle, wraps modulo 2^TS_WIDTH.
- **Detector FSM, 3 states**, evaluated every clock edge:
  - DISARMED: when enable_capture=0, go to (or stay in) DISARMED from any state. When enable_capture=1, go to HIGH if data>THRESHOLD (no capture, because no crossing was seen), otherwise go to ARMED.
  - ARMED: if data>THRESHOLD, capture the event and go to HIGH.
  - HIGH: if data<=THRESHOLD, go to ARMED. No capture while in HIGH.
- **Compare:** unsigned. A sample equal to THRESHOLD counts as not above.
- **Capture:** push {data_in_capture, ts} sampled at the same edge; ts is its pre-increment value.
- **FIFO:** show-ahead. rd_data and rd_timestamp always present the head entry and are don't-care when rd_valid=0.
  - A pop occurs when rd_valid && rd_ready.
  - Full and push with no pop: the push is dropped, overflow is set, and the FIFO contents are unchanged.
  - Full and push with a pop in the same cycle: both are performed and fifo_count stays at DEPTH.
  - Empty and push in the same cycle: the entry appears next cycle. There is no fall-through.
  - Pointers wrap modulo DEPTH.
- **overflow:** sticky. Cleared only by reset or clear_capture.
- **clear_capture:** takes priority over everything. Next cycle: fifo_count=0, overflow=0, ts=0, FSM=DISARMED. Any capture or pop in the clear cycle is discarded.

## Timing

- **Reset values:** rd_valid=0, fifo_count=0, overflow=0, rd_data=0, rd_timestamp=0, ts=0, FSM=DISARMED.
- **Reset assertion:** asynchronous. Asserting it mid-operation discards all entries immediately.
- **Capture latency:** 1 cycle. The entry is visible on rd_valid and fifo_count the cycle after the capturing edge.
- **Pop:** a pop at edge N presents the next head, or drops rd_valid, after edge N.
- **Threshold re-arm:** minimum spacing between two captures is 2 cycles (above, then <=, then above).
- **Enable timing:** enable_capture and data are sampled at the same edge. Enable rising while data is above the threshold never produces a capture.
- **Combinational paths:** none from inputs to outputs. All outputs are registered or decoded directly from registers.

## Test plan

- **Basic capture:** reset, enable=1, drive 50 then 150 at ts=5 → one entry {150, 5}. rd_valid rises the next cycle; fifo_count=1.
- **Crossing qualification:**
  - Drive 100 → no capture (equal to threshold is not above).
  - Drive 101, 120, 130 → exactly one capture (101).
  - Drive 90 → no capture; then 200 → second capture (200).
- **Enable gating:** enable rises while data=180 → no capture. Then 60 followed by 180 → one capture.
- **Overflow:**
  - With DEPTH=8 and rd_ready=0, generate 9 crossings → fifo_count=8, overflow=1, first 8 entries intact and in order.
  - Then one cycle with a crossing plus rd_ready=1 → count stays 8 and the new entry lands at the tail.
- **Drain and wrap:** push 12 events while popping intermittently → read order matches push order across pointer wrap. Timestamps are correct across the ts wrap from 16'hFFFF to 0.
- **Clear and reset mid-operation:**
  - With 3 entries and overflow=1, pulse clear with a simultaneous crossing → next cycle count=0, overflow=0, ts=0, no entry stored.
  - Assert rst_capture asynchronously mid-burst → outputs go to reset values immediately.

Source files
------------

// File: rtl/strobe_event_capture.sv
// Threshold-crossing event recorder.
// Watches the registered sample stream from the monitor stage. On every
// qualified rising crossing of THRESHOLD it stores {sample, timestamp} in a
// small show-ahead FIFO that is drained through a valid/ready read port.
//
// Read handshake: rd_valid is high whenever the FIFO holds an entry and
// rd_data/rd_timestamp then show the head entry; an entry is consumed on
// every rising clock edge where rd_valid && rd_ready. rd_valid never depends
// combinationally on rd_ready.
module strobe_event_capture #(
   parameter int DATA_WIDTH = 8,
   parameter int THRESHOLD  = 100,
   parameter int DEPTH      = 8,
   parameter int TS_WIDTH   = 16
) (
   input  logic                     clk_capture,
   input  logic                     rst_capture,
   input  logic [DATA_WIDTH-1:0]    data_in_capture,
   input  logic                     enable_capture,
   input  logic                     clear_capture,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [TS_WIDTH-1:0]      rd_timestamp,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [DATA_WIDTH-1:0] THRESH    = DATA_WIDTH'(THRESHOLD);
   localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      HIGH     = 2'd2
   } state_t;

   // Detector state is kept in a plainly named enum so checkers can bind to it.
   state_t state;
   state_t state_next;

   logic [TS_WIDTH-1:0]   ts;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [TS_WIDTH-1:0]   mem_ts   [DEPTH];

   logic above;
   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign above    = (data_in_capture > THRESH);
   assign full     = (count == DEPTH_CNT);
   assign rd_valid = (count != '0);
   assign pop      = rd_valid && rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push     = capture && (!full || pop);
   assign drop     = capture && full && !pop;

   assign fifo_count   = count;
   assign rd_data      = mem_data[rd_ptr];
   assign rd_timestamp = mem_ts[rd_ptr];

   // Detector next state: a capture only fires on a low-to-high move while armed.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      if (!enable_capture) begin
         state_next = DISARMED;
      end else begin
         case (state)
            DISARMED: state_next = above ? HIGH : ARMED;
            ARMED: begin
               if (above) begin
                  capture    = 1'b1;
                  state_next = HIGH;
               end
            end
            HIGH:     if (!above) state_next = ARMED;
            default:  state_next = DISARMED;
         endcase
      end
   end

   // Detector state register; clear forces it back to DISARMED.
   always_ff @(posedge clk_capture or posedge rst_capture) begin
      if (rst_capture)        state <= DISARMED;
      else if (clear_capture) state <= DISARMED;
      else                    state <= state_next;
   end

   // Free-running timestamp; the value pushed is the one before this increment.
   always_ff @(posedge clk_capture or posedge rst_capture) begin
      if (rst_capture)        ts <= '0;
      else if (clear_capture) ts <= '0;
      else                    ts <= ts + TS_WIDTH'(1);
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk_capture or posedge rst_capture) begin
      if (rst_capture) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear_capture) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (drop) overflow <= 1'b1;
      end
   end

   // FIFO storage; reset zeroes it so the head outputs read 0 out of reset.
   always_ff @(posedge clk_capture or posedge rst_capture) begin
      if (rst_capture) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_ts[i]   <= '0;
         end
      end else if (!clear_capture && push) begin
         mem_data[wr_ptr] <= data_in_capture;
         mem_ts[wr_ptr]   <= ts;
      end
   end

endmodule

// File: tb/tb_strobe_event_capture.sv
// Bench for strobe_event_capture: directed phases followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_strobe_event_capture;

   localparam int DW    = 8;
   localparam int TH    = 100;
   localparam int DEPTH = 8;
   localparam int TSW   = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          en  = 1'b0;
   logic          clr = 1'b0;
   logic          rdy = 1'b0;
   logic [DW-1:0] din = '0;

   logic           rd_valid;
   logic [DW-1:0]  rd_data;
   logic [TSW-1:0] rd_ts;
   logic [CW-1:0]  cnt;
   logic           ovf;

   strobe_event_capture #(
      .DATA_WIDTH (DW),
      .THRESHOLD  (TH),
      .DEPTH      (DEPTH),
      .TS_WIDTH   (TSW)
   ) dut (
      .clk_capture     (clk),
      .rst_capture     (rst),
      .data_in_capture (din),
      .enable_capture  (en),
      .clear_capture   (clr),
      .rd_ready        (rdy),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .rd_timestamp    (rd_ts),
      .fifo_count      (cnt),
      .overflow        (ovf)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An event is a sample above TH that immediately follows a sample at or
   // below TH, with enable high for both samples and no reset/clear between.
   logic [DW+TSW-1:0] exp_q[$];
   bit m_ovf      = 1'b0;
   int m_ts       = 0;
   bit prev_ok    = 1'b0;
   bit prev_en    = 1'b0;
   bit prev_above = 1'b0;
   bit m_above, m_cap, m_pop, m_full;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_ovf   = 1'b0;
         m_ts    = 0;
         prev_ok = 1'b0;
      end else if (clr) begin
         exp_q.delete();
         m_ovf   = 1'b0;
         m_ts    = 0;
         prev_ok = 1'b0;
      end else begin
         m_above = (int'(din) > TH);
         m_cap   = en && m_above && prev_ok && prev_en && !prev_above;
         m_full  = (exp_q.size() == DEPTH);
         m_pop   = (exp_q.size() != 0) && rdy;
         if (m_pop) void'(exp_q.pop_front());
         if (m_cap) begin
            if (!m_full || m_pop) exp_q.push_back({din, TSW'(m_ts)});
            else                  m_ovf = 1'b1;
         end
         m_ts       = (m_ts + 1) % (1 << TSW);
         prev_ok    = 1'b1;
         prev_en    = en;
         prev_above = m_above;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("fifo_count", 32'(cnt), 32'(exp_q.size()));
         chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
         chk("overflow", 32'(ovf), 32'(m_ovf));
         if (exp_q.size() != 0) begin
            chk("head_data", 32'(rd_data), 32'(exp_q[0][DW+TSW-1:TSW]));
            chk("head_ts", 32'(rd_ts), 32'(exp_q[0][TSW-1:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic e, input int d, input logic r, input logic c);
      en  = e;
      din = DW'(d);
      rdy = r;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_count"}, 32'(cnt), 32'd0);
      chk({tag, "_overflow"}, 32'(ovf), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({tag, "_rd_ts"}, 32'(rd_ts), 32'd0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int r;

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // basic capture
      cyc(1, 50, 0, 0);
      cyc(1, 150, 0, 0);
      chk("basic_count", 32'(cnt), 32'd1);
      chk("basic_data", 32'(rd_data), 32'd150);

      // crossing qualification: 100 no, 101 yes, 120/130 no, 90 no, 200 yes
      cyc(1, 100, 0, 0);
      cyc(1, 101, 0, 0);
      cyc(1, 120, 0, 0);
      cyc(1, 130, 0, 0);
      cyc(1, 90, 0, 0);
      cyc(1, 200, 0, 0);
      chk("qual_count", 32'(cnt), 32'd3);

      // enable gating
      cyc(0, 180, 0, 0);
      cyc(1, 180, 0, 0);
      chk("gate_no_capture", 32'(cnt), 32'd3);
      cyc(1, 60, 0, 0);
      cyc(1, 180, 0, 0);
      chk("gate_count", 32'(cnt), 32'd4);

      // overflow: 6 more crossings into a FIFO holding 4
      for (int i = 0; i < 6; i++) begin
         cyc(1, 50, 0, 0);
         cyc(1, 150 + i, 0, 0);
      end
      chk("ovf_count", 32'(cnt), 32'd8);
      chk("ovf_flag", 32'(ovf), 32'd1);
      cyc(1, 50, 0, 0);
      cyc(1, 222, 1, 0);
      chk("full_pushpop_count", 32'(cnt), 32'd8);

      // drain to 3, then clear together with a crossing
      for (int i = 0; i < 5; i++) cyc(1, 50, 1, 0);
      chk("pre_clear_count", 32'(cnt), 32'd3);
      cyc(1, 150, 0, 1);
      chk("clear_count", 32'(cnt), 32'd0);
      chk("clear_overflow", 32'(ovf), 32'd0);
      cyc(1, 50, 0, 0);
      cyc(1, 150, 0, 0);
      chk("clear_ts_restart", 32'(rd_ts), 32'd1);

      // randomized traffic with a mid-burst asynchronous reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset();
         r = $urandom_range(0, 3);
         cyc($urandom_range(0, 15) != 0,
             (r == 0) ? TH : (r == 1) ? $urandom_range(0, TH) : $urandom_range(TH + 1, 255),
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 299) == 0);
      end

      // final drain
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
      chk("final_drained", 32'(cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
